// File: rtl/rca_config_bank_pkg.sv
// rca_config_bank_pkg: sizing defaults and shared types for the RCA configuration bank
package rca_config_bank_pkg;
   localparam int DEF_NUM_RCAS        = 2;
   localparam int DEF_NUM_READ_PORTS  = 5;
   localparam int DEF_NUM_WRITE_PORTS = 2;
   localparam int DEF_RS_W = DEF_NUM_RCAS > 1 ? $clog2(DEF_NUM_RCAS) : 1;
   localparam int DEF_PS_W = $clog2(DEF_NUM_READ_PORTS > DEF_NUM_WRITE_PORTS ? DEF_NUM_READ_PORTS : DEF_NUM_WRITE_PORTS);
   typedef enum logic [1:0] {IDLE, DRAIN, SWAP} rca_cfg_state_t;
   typedef struct packed {
      logic [DEF_RS_W-1:0] rca_sel;
      logic                src_dest;
      logic [DEF_PS_W-1:0] port_sel;
      logic [4:0]          reg_addr;
   } rca_cfg_write_t;
endpackage

// File: rtl/rca_config_entry.sv
// rca_config_entry: shadow and active register-address banks for one RCA
module rca_config_entry #(
   parameter int NR   = 5,
   parameter int NW   = 2,
   parameter int PS_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we_i,
   input  logic                 src_dest_i,
   input  logic [PS_W-1:0]      port_sel_i,
   input  logic [4:0]           addr_i,
   input  logic                 copy_i,
   output logic [NR-1:0][4:0]   src_o,
   output logic [NW-1:0][4:0]   dest_o,
   output logic                 valid_o
);
   logic [NR-1:0][4:0] shd_src_q, act_src_q;
   logic [NW-1:0][4:0] shd_dest_q, act_dest_q;
   logic               valid_q;
   // Shadow writes land per slot; the copy strobe snapshots the whole shadow into active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_src_q  <= '0;
         shd_dest_q <= '0;
         act_src_q  <= '0;
         act_dest_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         for (int k = 0; k < NR; k++)
            if (we_i && !src_dest_i && port_sel_i == PS_W'(k)) shd_src_q[k] <= addr_i;
         for (int k = 0; k < NW; k++)
            if (we_i && src_dest_i && port_sel_i == PS_W'(k)) shd_dest_q[k] <= addr_i;
         if (copy_i) begin
            act_src_q  <= shd_src_q;
            act_dest_q <= shd_dest_q;
            valid_q    <= 1'b1;
         end
      end
   end
   assign src_o   = act_src_q;
   assign dest_o  = act_dest_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/rca_config_bank.sv
// rca_config_bank: double-buffered per-RCA register-address configuration with drain-then-swap commit
module rca_config_bank
   import rca_config_bank_pkg::*;
#(
   parameter int NUM_RCAS        = DEF_NUM_RCAS,
   parameter int NUM_READ_PORTS  = DEF_NUM_READ_PORTS,
   parameter int NUM_WRITE_PORTS = DEF_NUM_WRITE_PORTS,
   localparam int RS_W = NUM_RCAS > 1 ? $clog2(NUM_RCAS) : 1,
   localparam int PMAX = NUM_READ_PORTS > NUM_WRITE_PORTS ? NUM_READ_PORTS : NUM_WRITE_PORTS,
   localparam int PS_W = PMAX > 1 ? $clog2(PMAX) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [RS_W-1:0]                  cfg_rca_sel,
   input  logic                             cfg_src_dest,
   input  logic [PS_W-1:0]                  cfg_port_sel,
   input  logic [4:0]                       cfg_reg_addr,
   output logic                             cfg_error,
   input  logic                             commit_valid,
   input  logic [RS_W-1:0]                  commit_rca_sel,
   output logic                             commit_ready,
   input  logic [NUM_RCAS-1:0]              rca_busy,
   input  logic [RS_W-1:0]                  use_rca_sel,
   output logic                             use_valid,
   output logic [NUM_READ_PORTS-1:0][4:0]   src_reg_addrs,
   output logic [NUM_WRITE_PORTS-1:0][4:0]  dest_reg_addrs
);
   rca_cfg_state_t state_q, state_d;
   logic [RS_W-1:0] tgt_q, tgt_d;
   logic err_q, wr_acc, slot_ok, cm_ok, cm_busy, tgt_ok, tgt_busy, use_ok;
   logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][4:0]  act_src;
   logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][4:0] act_dest;
   logic [NUM_RCAS-1:0]                           act_val;

   assign wr_acc   = cfg_valid && cfg_ready;
   assign slot_ok  = cfg_src_dest ? {1'b0, cfg_port_sel} < (PS_W+1)'(NUM_WRITE_PORTS)
                                  : {1'b0, cfg_port_sel} < (PS_W+1)'(NUM_READ_PORTS);
   assign cm_ok    = {1'b0, commit_rca_sel} < (RS_W+1)'(NUM_RCAS);
   assign cm_busy  = cm_ok ? rca_busy[commit_rca_sel] : 1'b0;
   assign tgt_ok   = {1'b0, tgt_q} < (RS_W+1)'(NUM_RCAS);
   assign tgt_busy = tgt_ok ? rca_busy[tgt_q] : 1'b0;
   assign use_ok   = {1'b0, use_rca_sel} < (RS_W+1)'(NUM_RCAS);

   // Commit FSM state, latched target RCA and the registered bad-slot pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         err_q   <= wr_acc && !slot_ok;
      end
   end

   // Next state: a commit waits out the target's in-flight work before the one-cycle swap
   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      cfg_ready    = state_q == IDLE;
      commit_ready = state_q == IDLE;
      if (state_q == IDLE && commit_valid) begin
         tgt_d   = commit_rca_sel;
         state_d = cm_busy ? DRAIN : SWAP;
      end else if (state_q == DRAIN && !tgt_busy) begin
         state_d = SWAP;
      end else if (state_q == SWAP) begin
         state_d = IDLE;
      end
   end

   for (genvar g = 0; g < NUM_RCAS; g++) begin : g_entry
      rca_config_entry #(
         .NR  (NUM_READ_PORTS),
         .NW  (NUM_WRITE_PORTS),
         .PS_W(PS_W)
      ) u_entry (
         .clk       (clk),
         .rst_n     (rst_n),
         .we_i      (wr_acc && slot_ok && cfg_rca_sel == RS_W'(g)),
         .src_dest_i(cfg_src_dest),
         .port_sel_i(cfg_port_sel),
         .addr_i    (cfg_reg_addr),
         .copy_i    (state_q == SWAP && tgt_q == RS_W'(g)),
         .src_o     (act_src[g]),
         .dest_o    (act_dest[g]),
         .valid_o   (act_val[g])
      );
   end

   assign cfg_error      = err_q;
   assign use_valid      = use_ok ? act_val[use_rca_sel]  : 1'b0;
   assign src_reg_addrs  = use_ok ? act_src[use_rca_sel]  : '0;
   assign dest_reg_addrs = use_ok ? act_dest[use_rca_sel] : '0;
endmodule

// File: tb/tb_rca_config_bank.sv
// tb_rca_config_bank: randomized self-checking bench against a shadow/active array model
module tb_rca_config_bank;
   logic            clk = 1'b0, rst_n = 1'b0;
   logic            cfg_valid = 1'b0, cfg_ready, cfg_src_dest = 1'b0, cfg_error;
   logic [0:0]      cfg_rca_sel = '0, commit_rca_sel = '0, use_rca_sel = '0;
   logic [2:0]      cfg_port_sel = '0;
   logic [4:0]      cfg_reg_addr = '0;
   logic            commit_valid = 1'b0, commit_ready, use_valid;
   logic [1:0]      rca_busy = '0;
   logic [4:0][4:0] src_reg_addrs;
   logic [1:0][4:0] dest_reg_addrs;
   int checks = 0, errors = 0;

   logic [4:0] ssrc[2][5], sdst[2][2], asrc[2][5], adst[2][2];
   bit         aval[2];

   rca_config_bank dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_rca_sel(cfg_rca_sel), .cfg_src_dest(cfg_src_dest), .cfg_port_sel(cfg_port_sel),
      .cfg_reg_addr(cfg_reg_addr), .cfg_error(cfg_error), .commit_valid(commit_valid),
      .commit_rca_sel(commit_rca_sel), .commit_ready(commit_ready), .rca_busy(rca_busy),
      .use_rca_sel(use_rca_sel), .use_valid(use_valid), .src_reg_addrs(src_reg_addrs),
      .dest_reg_addrs(dest_reg_addrs)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [35:0] exp_all(input int r);
      logic [24:0] s;
      logic [9:0]  d;
      s = '0;
      d = '0;
      if (r > 1) return '0;
      for (int p = 0; p < 5; p++) s[p*5 +: 5] = asrc[r][p];
      for (int p = 0; p < 2; p++) d[p*5 +: 5] = adst[r][p];
      return {aval[r], s, d};
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         aval[r] = 0;
         for (int p = 0; p < 5; p++) begin ssrc[r][p] = '0; asrc[r][p] = '0; end
         for (int p = 0; p < 2; p++) begin sdst[r][p] = '0; adst[r][p] = '0; end
      end
   endtask

   task automatic model_write(input int r, input int sd, input int p, input logic [4:0] a);
      if (sd == 0 && p < 5) ssrc[r][p] = a;
      if (sd == 1 && p < 2) sdst[r][p] = a;
   endtask

   task automatic model_commit(input int r);
      asrc[r] = ssrc[r];
      adst[r] = sdst[r];
      aval[r] = 1;
   endtask

   task automatic do_write(input int r, input int sd, input int p, input logic [4:0] a);
      bit bad;
      cfg_rca_sel = 1'(r); cfg_src_dest = sd[0]; cfg_port_sel = 3'(p); cfg_reg_addr = a;
      cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      bad = sd ? p >= 2 : p >= 5;
      model_write(r, sd, p, a);
      checks++;
      if (cfg_error !== bad) begin
         errors++;
         $display("FAIL cfg_error_after_write: got %b expected %b (rca %0d sd %0d port %0d)", cfg_error, bad, r, sd, p);
      end
   endtask

   task automatic do_commit(input int r, input int busy_cyc);
      int n;
      rca_busy[r] = busy_cyc > 0;
      commit_rca_sel = 1'(r);
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      repeat (busy_cyc) begin @(posedge clk); #1; end
      rca_busy = '0;
      n = 0;
      while (!cfg_ready && n < 10) begin @(posedge clk); #1; n++; end
      model_commit(r);
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL commit_return_idle: got cfg_ready %b expected 1 within bound", cfg_ready);
      end
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      for (int r = 0; r < 2; r++) begin
         use_rca_sel = 1'(r); #1;
         checks++;
         if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
            errors++;
            $display("FAIL reset_outputs rca%0d: got %h expected %h", r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
         end
      end
      checks++;
      if ({cfg_ready, commit_ready, cfg_error} !== 3'b110) begin
         errors++;
         $display("FAIL reset_handshake: got %b expected 110", {cfg_ready, commit_ready, cfg_error});
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic_commit();
      do_write(1, 0, 2, 5'd7);
      use_rca_sel = 1'b1;
      commit_rca_sel = 1'b1;
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      checks++;
      if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(1)) begin
         errors++;
         $display("FAIL commit_too_early: got %h expected %h", {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(1));
      end
      @(posedge clk); #1;
      model_commit(1);
      checks++;
      if (src_reg_addrs[2] !== 5'd7 || use_valid !== 1'b1) begin
         errors++;
         $display("FAIL commit_latency_2: got src2 %0d valid %b expected 7 and 1", src_reg_addrs[2], use_valid);
      end
      checks++;
      if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(1)) begin
         errors++;
         $display("FAIL commit_contents: got %h expected %h", {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(1));
      end
   endtask

   task automatic test_bad_slot();
      do_write(0, 1, 3, 5'd21);
      @(posedge clk); #1;
      checks++;
      if (cfg_error !== 1'b0) begin
         errors++;
         $display("FAIL cfg_error_one_cycle: got %b expected 0", cfg_error);
      end
      do_write(1, 0, 6, 5'd9);
      do_commit(0, 0);
      do_commit(1, 0);
      for (int r = 0; r < 2; r++) begin
         use_rca_sel = 1'(r); #1;
         checks++;
         if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
            errors++;
            $display("FAIL bad_slot_no_change rca%0d: got %h expected %h", r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
         end
      end
   endtask

   task automatic test_drain();
      do_write(0, 0, 0, 5'd13);
      do_write(0, 1, 1, 5'd30);
      use_rca_sel = 1'b0;
      rca_busy = 2'b01;
      commit_rca_sel = 1'b0;
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({cfg_ready, commit_ready} !== 2'b00 || {use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(0)) begin
            errors++;
            $display("FAIL drain_hold cyc%0d: got ready %b out %h expected 00 out %h", i, {cfg_ready, commit_ready}, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(0));
         end
         @(posedge clk); #1;
      end
      use_rca_sel = 1'b1; #1;
      checks++;
      if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(1)) begin
         errors++;
         $display("FAIL drain_other_rca: got %h expected %h", {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(1));
      end
      use_rca_sel = 1'b0;
      rca_busy = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (cfg_ready !== 1'b0 || {use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(0)) begin
         errors++;
         $display("FAIL drain_swap_cycle: got ready %b out %h expected 0 out %h", cfg_ready, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(0));
      end
      @(posedge clk); #1;
      model_commit(0);
      checks++;
      if (cfg_ready !== 1'b1 || {use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(0)) begin
         errors++;
         $display("FAIL drain_commit_done: got ready %b out %h expected 1 out %h", cfg_ready, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(0));
      end
   endtask

   task automatic test_same_cycle();
      logic [4:0] a;
      a = 5'($urandom_range(1, 31));
      use_rca_sel = 1'b1;
      cfg_rca_sel = 1'b1; cfg_src_dest = 1'b1; cfg_port_sel = 3'd1; cfg_reg_addr = a;
      cfg_valid = 1'b1;
      commit_rca_sel = 1'b1;
      commit_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      commit_valid = 1'b0;
      model_write(1, 1, 1, a);
      @(posedge clk); #1;
      model_commit(1);
      checks++;
      if (dest_reg_addrs[1] !== a || {use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(1)) begin
         errors++;
         $display("FAIL same_cycle_write_commit: got %h expected %h", {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(1));
      end
   endtask

   task automatic test_reset_drain();
      do_write(0, 0, 1, 5'd19);
      rca_busy = 2'b01;
      commit_rca_sel = 1'b0;
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async_idle: got cfg_ready %b expected 1", cfg_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      rca_busy = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_idle: got cfg_ready %b expected 1", cfg_ready);
      end
      for (int r = 0; r < 2; r++) begin
         use_rca_sel = 1'(r); #1;
         checks++;
         if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
            errors++;
            $display("FAIL reset_drain_cleared rca%0d: got %h expected %h", r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
         end
      end
   endtask

   task automatic test_shadow_only();
      do_commit(1, 0);
      for (int i = 0; i < 4; i++) begin
         do_write(0, i % 2, $urandom_range(0, 1), 5'($urandom));
         for (int r = 0; r < 2; r++) begin
            use_rca_sel = 1'(r); #1;
            checks++;
            if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
               errors++;
               $display("FAIL shadow_only rca%0d: got %h expected %h", r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
            end
         end
      end
      do_commit(0, 0);
      for (int r = 0; r < 2; r++) begin
         use_rca_sel = 1'(r); #1;
         checks++;
         if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
            errors++;
            $display("FAIL shadow_then_commit rca%0d: got %h expected %h", r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) != 0)
            do_write($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), 5'($urandom));
         else
            do_commit($urandom_range(0, 1), $urandom_range(0, 3));
         for (int r = 0; r < 2; r++) begin
            use_rca_sel = 1'(r); #1;
            checks++;
            if ({use_valid, src_reg_addrs, dest_reg_addrs} !== exp_all(r)) begin
               errors++;
               $display("FAIL random_op%0d rca%0d: got %h expected %h", i, r, {use_valid, src_reg_addrs, dest_reg_addrs}, exp_all(r));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_commit();
      test_bad_slot();
      test_drain();
      test_same_cycle();
      test_reset_drain();
      test_shadow_only();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
